d1s_resp_checker: RTL

- Downstream response checker for the 3-input combinational d1s stage.
- Consumes each applied input vector {a,b,c} together with the stage output d.
- Waits a programmable settle time, then samples d and compares it with an expected truth table.
- Accumulates an 8-bit observed signature, a coverage mask and an error count, and flags pass/fail once all 8 vectors have been checked.

---
 rtl/d1s_resp_checker.sv | 115 +++++++++++
 1 files changed

// File: rtl/d1s_resp_checker.sv
// Response checker for the 3-input d1s stage: applies a settle delay per vector,
// samples d, and accumulates signature, coverage and error count against EXPECTED.
module d1s_resp_checker #(
  parameter logic [7:0]  EXPECTED = 8'b1110_1000,
  parameter int unsigned SETTLE   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       vec_valid,
  output logic       vec_ready,
  input  logic [2:0] vec,
  input  logic       d_in,
  output logic [7:0] signature,
  output logic [7:0] seen,
  output logic [3:0] err_cnt,
  output logic       mismatch,
  output logic       done,
  output logic       pass,
  output logic [2:0] state_dbg
);

  // Handshake: a vector transfers on a rising edge where vec_valid && vec_ready;
  // vec_ready is high only in WAIT, and vec may change after the accepting edge.

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WAIT   = 3'd1,
    S_SETTLE = 3'd2,
    S_SAMPLE = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE - 1);

  state_t     state;
  logic [3:0] cnt;
  logic [2:0] vec_q;

  logic [7:0] seen_upd;
  logic       miss;
  logic [3:0] err_next;

  assign state_dbg = state;

  always_comb begin
    seen_upd = seen | (8'd1 << vec_q);
    miss     = (d_in != EXPECTED[vec_q]);
    err_next = err_cnt;
    if (miss && (err_cnt != 4'hF)) err_next = err_cnt + 4'd1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      vec_q     <= 3'd0;
      signature <= 8'd0;
      seen      <= 8'd0;
      err_cnt   <= 4'd0;
      mismatch  <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      vec_ready <= 1'b0;
    end else begin
      mismatch <= 1'b0;
      // start overrides everything, discarding any vector still settling
      if (start) begin
        state     <= S_WAIT;
        signature <= 8'd0;
        seen      <= 8'd0;
        err_cnt   <= 4'd0;
        done      <= 1'b0;
        pass      <= 1'b0;
        vec_ready <= 1'b1;
      end else begin
        case (state)
          S_IDLE: vec_ready <= 1'b0;
          S_WAIT: begin
            if (vec_valid && vec_ready) begin
              vec_q     <= vec;
              cnt       <= SETTLE_LOAD;
              state     <= S_SETTLE;
              vec_ready <= 1'b0;
            end
          end
          S_SETTLE: begin
            if (cnt == 4'd0) state <= S_SAMPLE;
            else             cnt   <= cnt - 4'd1;
          end
          S_SAMPLE: begin
            signature[vec_q] <= d_in;
            seen             <= seen_upd;
            mismatch         <= miss;
            err_cnt          <= err_next;
            if (seen_upd == 8'hFF) begin
              state <= S_DONE;
              done  <= 1'b1;
              pass  <= (err_next == 4'd0);
            end else begin
              state     <= S_WAIT;
              vec_ready <= 1'b1;
            end
          end
          S_DONE: vec_ready <= 1'b0;
          default: begin
            state     <= S_IDLE;
            vec_ready <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
